// File: rtl/mt_fetch.sv
// mt_fetch -- barrel-threaded instruction fetch stage.
//
// Keeps one PC per hardware thread. Each cycle it picks the next enabled
// thread round-robin, reads instruction memory at that thread's PC and
// registers pc/instr/tid into the F/D boundary. Taken branches and jumps
// resolved in execute overwrite the owning thread's PC.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   thread_en       per-thread scheduling enable mask
//   stall_f         hold pointer, PCs and F/D (redirect writes still land)
//   pc_src_e        redirect request from execute
//   pc_target_e     redirect target address
//   tid_e           thread owning the redirect
//   imem_addr       combinational instruction memory address
//   imem_rdata      instruction word for imem_addr, same cycle
//   pc_f            registered PC of instr_f
//   pc_plus4_f      registered pc_f + 4
//   instr_f         registered instruction, NOP when not valid
//   tid_f           registered thread id of instr_f
//   valid_f         instr_f is a real instruction
//   kill_d          squash the instruction currently held in F/D
module mt_fetch #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       NUM_THREADS   = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  localparam int                      BITS_THREADS  = $clog2(NUM_THREADS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_THREADS-1:0]   thread_en,
  input  logic                     stall_f,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  input  logic [BITS_THREADS-1:0]  tid_e,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  output logic [DATA_WIDTH-1:0]    instr_f,
  output logic [BITS_THREADS-1:0]  tid_f,
  output logic                     valid_f,
  output logic                     kill_d
);

  localparam logic [DATA_WIDTH-1:0]    NOP   = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDRESS_WIDTH-1:0] FOUR  = ADDRESS_WIDTH'(4);
  localparam logic [BITS_THREADS-1:0]  LAST  = BITS_THREADS'(NUM_THREADS - 1);

  logic [ADDRESS_WIDTH-1:0] pc_reg [NUM_THREADS];
  logic [BITS_THREADS-1:0]  last_tid;

  logic [BITS_THREADS-1:0]  sel;
  logic [BITS_THREADS-1:0]  cand;
  logic                     found;
  logic                     issue;
  logic                     redirect_hit;
  logic [ADDRESS_WIDTH-1:0] sel_pc;

  // Round-robin scan starting just after last_tid; NUM_THREADS is a power of
  // two, so the pointer add wraps naturally and the final candidate is
  // last_tid itself.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so
    // no path leaves it unassigned and a latch is never inferred.
    sel   = last_tid;
    cand  = last_tid;
    found = 1'b0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      cand = last_tid + BITS_THREADS'(i);
      if (!found && thread_en[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign issue        = |thread_en;
  assign sel_pc       = issue ? pc_reg[sel] : pc_reg[last_tid];
  assign imem_addr    = sel_pc;
  // The selected fetch is on the wrong path when its own thread is redirected
  // in the same cycle.
  assign redirect_hit = issue && pc_src_e && (tid_e == sel);
  assign kill_d       = pc_src_e && valid_f && (tid_f == tid_e);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the PC file is small architectural state that must start at
      // RESET_PC, so unlike a data memory every entry is reset here.
      for (int t = 0; t < NUM_THREADS; t++) pc_reg[t] <= RESET_PC;
      last_tid   <= LAST;
      pc_f       <= RESET_PC;
      pc_plus4_f <= RESET_PC + FOUR;
      instr_f    <= NOP;
      tid_f      <= '0;
      valid_f    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments; the redirect write below is the later
      // assignment, so it overrides the +4 when both target the same thread.
      if (!stall_f && issue) pc_reg[sel] <= pc_reg[sel] + FOUR;
      if (pc_src_e)          pc_reg[tid_e] <= pc_target_e;

      if (!stall_f) begin
        if (issue) begin
          last_tid   <= sel;
          pc_f       <= pc_reg[sel];
          pc_plus4_f <= pc_reg[sel] + FOUR;
          tid_f      <= sel;
          instr_f    <= redirect_hit ? NOP : imem_rdata;
          valid_f    <= !redirect_hit;
        end else begin
          instr_f <= NOP;
          valid_f <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mt_fetch.sv
// tb_mt_fetch -- directed self-checking bench for mt_fetch.
// Instruction memory returns addr|1, so every valid instr_f encodes its PC.
module tb_mt_fetch;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NT = 4;
  localparam int BT = 2;
  localparam logic [DW-1:0] NOP = 32'h0000_0013;

  typedef logic [AW+AW+DW+BT:0] fd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NT-1:0] thread_en;
  logic          stall_f;
  logic          pc_src_e;
  logic [AW-1:0] pc_target_e;
  logic [BT-1:0] tid_e;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic [AW-1:0] pc_f;
  logic [AW-1:0] pc_plus4_f;
  logic [DW-1:0] instr_f;
  logic [BT-1:0] tid_f;
  logic          valid_f;
  logic          kill_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr | 32'h1;

  mt_fetch #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .NUM_THREADS  (NT),
    .RESET_PC     (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .thread_en  (thread_en),
    .stall_f    (stall_f),
    .pc_src_e   (pc_src_e),
    .pc_target_e(pc_target_e),
    .tid_e      (tid_e),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .pc_f       (pc_f),
    .pc_plus4_f (pc_plus4_f),
    .instr_f    (instr_f),
    .tid_f      (tid_f),
    .valid_f    (valid_f),
    .kill_d     (kill_d)
  );

  fd_t fd_act;
  assign fd_act = {pc_f, pc_plus4_f, instr_f, tid_f, valid_f};

  // Expected F/D contents: pc, pc+4, addr|1 or NOP, tid, valid.
  function automatic fd_t exp_fd(logic [AW-1:0] pc, logic [BT-1:0] tid, logic v);
    return {pc, pc + 32'd4, (v ? (pc | 32'h1) : NOP), tid, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fd_t e;
    rst = 1'b1; thread_en = '0; stall_f = 1'b0;
    pc_src_e = 1'b0; pc_target_e = '0; tid_e = '0;
    tick(); tick();
    e = exp_fd(32'h0, 2'd0, 1'b0);
    n_checks++;
    if (fd_act !== e) begin
      n_fail++; $display("FAIL reset_fd actual=%h required=%h", fd_act, e);
    end
    n_checks++;
    if (kill_d !== 1'b0 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_comb actual kill=%b addr=%h required kill=0 addr=0", kill_d, imem_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    fd_t e;
    thread_en = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = exp_fd(32'((i / 4) * 4), 2'(i % 4), 1'b1);
      n_checks++;
      if (fd_act !== e) begin
        n_fail++; $display("FAIL round_robin_%0d actual=%h required=%h", i, fd_act, e);
      end
    end
  endtask

  task automatic test_mask();
    fd_t e;
    logic [BT-1:0] tids [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [AW-1:0] pcs  [4] = '{32'd8, 32'd8, 32'd12, 32'd12};
    thread_en = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = exp_fd(pcs[i], tids[i], 1'b1);
      n_checks++;
      if (fd_act !== e) begin
        n_fail++; $display("FAIL mask_0101_%0d actual=%h required=%h", i, fd_act, e);
      end
    end
    // All disabled: bubble with held pc/tid; address shows last thread's PC.
    thread_en = 4'b0000;
    #1;
    n_checks++;
    if (imem_addr !== 32'd16) begin
      n_fail++; $display("FAIL idle_addr actual=%h required=%h", imem_addr, 32'd16);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_fd(32'd12, 2'd2, 1'b0);
      n_checks++;
      if (fd_act !== e) begin
        n_fail++; $display("FAIL idle_%0d actual=%h required=%h", i, fd_act, e);
      end
    end
    thread_en = 4'b0101;
    tick();
    e = exp_fd(32'd16, 2'd0, 1'b1);
    n_checks++;
    if (fd_act !== e) begin
      n_fail++; $display("FAIL resume_t0 actual=%h required=%h", fd_act, e);
    end
    tick();
    e = exp_fd(32'd16, 2'd2, 1'b1);
    n_checks++;
    if (fd_act !== e) begin
      n_fail++; $display("FAIL resume_t2 actual=%h required=%h", fd_act, e);
    end
  endtask

  task automatic test_redirect_other();
    fd_t e;
    logic [BT-1:0] tids [8] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    logic [AW-1:0] pcs  [8] = '{32'd8, 32'd20, 32'd8, 32'h100,
                                32'd12, 32'd24, 32'd12, 32'h104};
    thread_en = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        pc_src_e = 1'b1; tid_e = 2'd2; pc_target_e = 32'h100;
        #1;
        n_checks++;
        if (kill_d !== 1'b0) begin
          n_fail++; $display("FAIL redirect_other_kill actual=%b required=0", kill_d);
        end
      end
      tick();
      pc_src_e = 1'b0;
      e = exp_fd(pcs[i], tids[i], 1'b1);
      n_checks++;
      if (fd_act !== e) begin
        n_fail++; $display("FAIL redirect_other_%0d actual=%h required=%h", i, fd_act, e);
      end
    end
  endtask

  task automatic test_single_kill();
    fd_t e;
    thread_en = 4'b0001;
    tick();
    e = exp_fd(32'd28, 2'd0, 1'b1);
    n_checks++;
    if (fd_act !== e) begin
      n_fail++; $display("FAIL single_first actual=%h required=%h", fd_act, e);
    end
    pc_src_e = 1'b1; tid_e = 2'd0; pc_target_e = 32'h200;
    #1;
    n_checks++;
    if (kill_d !== 1'b1) begin
      n_fail++; $display("FAIL single_kill actual=%b required=1", kill_d);
    end
    tick();
    pc_src_e = 1'b0;
    e = exp_fd(32'd32, 2'd0, 1'b0);
    n_checks++;
    if (fd_act !== e) begin
      n_fail++; $display("FAIL single_squash actual=%h required=%h", fd_act, e);
    end
    tick();
    e = exp_fd(32'h200, 2'd0, 1'b1);
    n_checks++;
    if (fd_act !== e) begin
      n_fail++; $display("FAIL single_target actual=%h required=%h", fd_act, e);
    end
  endtask

  task automatic test_stall();
    fd_t e;
    thread_en = 4'b1111;
    stall_f = 1'b1;
    e = exp_fd(32'h200, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        pc_src_e = 1'b1; tid_e = 2'd1; pc_target_e = 32'h80;
        #1;
        n_checks++;
        if (imem_addr !== 32'd16) begin
          n_fail++; $display("FAIL stall_addr_pre actual=%h required=%h", imem_addr, 32'd16);
        end
      end
      tick();
      pc_src_e = 1'b0;
      #1;
      n_checks++;
      if (fd_act !== e) begin
        n_fail++; $display("FAIL stall_hold_%0d actual=%h required=%h", i, fd_act, e);
      end
      if (i == 1) begin
        n_checks++;
        if (imem_addr !== 32'h80) begin
          n_fail++; $display("FAIL stall_addr_post actual=%h required=%h", imem_addr, 32'h80);
        end
      end
    end
    stall_f = 1'b0;
    tick();
    e = exp_fd(32'h80, 2'd1, 1'b1);
    n_checks++;
    if (fd_act !== e) begin
      n_fail++; $display("FAIL stall_release actual=%h required=%h", fd_act, e);
    end
  endtask

  task automatic test_reset_midrun_wrap();
    fd_t e;
    thread_en = 4'b1111;
    tick();
    #2;
    rst = 1'b1;
    #1;
    e = exp_fd(32'h0, 2'd0, 1'b0);
    n_checks++;
    if (fd_act !== e) begin
      n_fail++; $display("FAIL midrun_reset actual=%h required=%h", fd_act, e);
    end
    // A redirect presented during reset must not survive it.
    pc_src_e = 1'b1; tid_e = 2'd0; pc_target_e = 32'h300;
    tick();
    pc_src_e = 1'b0;
    rst = 1'b0;
    tick();
    e = exp_fd(32'h0, 2'd0, 1'b1);
    n_checks++;
    if (fd_act !== e) begin
      n_fail++; $display("FAIL post_reset_first actual=%h required=%h", fd_act, e);
    end
    thread_en = 4'b0001;
    pc_src_e = 1'b1; tid_e = 2'd0; pc_target_e = 32'hFFFF_FFFC;
    tick();
    pc_src_e = 1'b0;
    e = exp_fd(32'h4, 2'd0, 1'b0);
    n_checks++;
    if (fd_act !== e) begin
      n_fail++; $display("FAIL wrap_squash actual=%h required=%h", fd_act, e);
    end
    tick();
    e = exp_fd(32'hFFFF_FFFC, 2'd0, 1'b1);
    n_checks++;
    if (fd_act !== e) begin
      n_fail++; $display("FAIL wrap_top actual=%h required=%h", fd_act, e);
    end
    tick();
    e = exp_fd(32'h0, 2'd0, 1'b1);
    n_checks++;
    if (fd_act !== e) begin
      n_fail++; $display("FAIL wrap_zero actual=%h required=%h", fd_act, e);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_mask();
    test_redirect_other();
    test_single_kill();
    test_stall();
    test_reset_midrun_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
